ef_tcc_nch: RTL and testbench
=============================

// Module: ef_tcc_nch
// PURPOSE
//  Parametrised timer/counter with CH_NUM compare/capture channels. Successor of the 32-bit single-channel TCC.
//  Adds configurable width, up/down/up-down modes, per-channel PWM compare and per-channel input capture.
//  Sits behind a bus-wrapper register file; all config inputs are quasi-static register outputs.
// PARAMETERS
//  WIDTH   32  counter, period, compare and capture width (8..32)
//  CH_NUM  4   number of compare/capture channels (1..8)
// PORTS
//  clk       in   1             system clock, all logic on rising edge
//  rst       in   1             asynchronous, active-high reset
//  en        in   1             block enable; 0 = prescaler/counter/flags held in reset state
//  tmr_en    in   1             counter run request
//  clk_src   in   4             tick source: 0..8 = clk/2^n, 9 = ctr_in rising edge, 10..15 = no tick
//  ctr_in    in   1             external count input (asynchronous)
//  dir       in   2             0 = up, 1 = down, 2 = up-down, 3 = reserved (treated as up)
//  one_shot  in   1             1 = stop after first timeout
//  period    in   WIDTH         terminal value
//  ch_mode   in   CH_NUM        per channel: 0 = compare/PWM, 1 = capture
//  ch_cmp    in   CH_NUM*WIDTH  compare values, channel i at [i*WIDTH +: WIDTH]
//  cap_edge  in   2*CH_NUM      per channel: 00 none, 01 rise, 10 fall, 11 both
//  cap_in    in   CH_NUM        capture inputs (asynchronous)
//  tmr       out  WIDTH         current count
//  cap_val   out  CH_NUM*WIDTH  captured counts
//  pwm_out   out  CH_NUM        PWM outputs (0 in capture mode)
//  to_flag   out  1             timeout pulse, 1 clk
//  match_flag out CH_NUM        compare-match pulses, 1 clk
//  cap_flag  out  CH_NUM        capture pulses, 1 clk
// BEHAVIOUR
//  - Reset (rst=1 or en=0): tmr=0, cap_val=0, pwm_out=0, all flags 0, prescaler=0, run=0, dir_state=up.
//  - Tick: prescaler free-runs while en; clk/2^n ticks on prescaler[n-1:0]==all-ones (n=0: every clk).
//    Source 9: ctr_in via 2-FF sync + edge detect; tick 3 clk after the input edge; inputs at most clk/4.
//  - Start: tmr_en 0->1 sets run and loads tmr (up/up-down: 0, down: period) next clk; no tick consumed.
//    tmr_en=0 clears run; tmr holds its value.
//  - Per tick while run:
//    - up: tmr==period -> to_flag, tmr<=0.
//    - down: tmr==0 -> to_flag, tmr<=period.
//    - up-down: count up to period, reverse, count down to 0; to_flag at 0 only.
//    - one_shot: at timeout, run<=0 and tmr holds the terminal value (up: period, down: 0).
//  - period==0: timeout on every tick; tmr stays 0.
//  - Compare ch i: on a tick where next tmr==ch_cmp[i], match_flag[i] pulses with the tmr update.
//    - pwm_out[i] set when tmr reloads/starts, cleared on match.
//    - ch_cmp[i]==0 forces pwm low; ch_cmp[i]>period forces pwm high.
//    - up-down: set on match counting down, clear on match counting up (centre-aligned).
//  - Capture ch i: cap_in via 2-FF sync + edge detect. On the selected edge, cap_val[i] <= tmr (value before
//    any same-cycle update) and cap_flag[i] pulses. Capture works while en=1 regardless of run.
//  - Simultaneous timeout, match and capture in one cycle: all flags assert together; none is dropped.
//  - Flags are registered; all outputs registered. Arithmetic is unsigned WIDTH-bit, no overflow past period.
//  - Config change mid-run takes effect at the next tick; period lowered below tmr: up counts through wrap
//    to 0 via 2^WIDTH rollover, no timeout until ==period.
// STRUCTURE
//  - Package ef_tcc_pkg:
//    - CLK_SRC_EXT=4'd9, DIR_UP/DIR_DOWN/DIR_UPDOWN encodings.
//    - CAP_RISE/CAP_FALL/CAP_BOTH encodings.
//    - CH_COMPARE/CH_CAPTURE mode constants.
//  - Sub-module ef_tcc_sync_edge: 2-FF synchroniser plus rise/fall pulse outputs, async active-high reset.
//    Instantiated for ctr_in and each cap_in (generate loop).
//  - Top: prescaler, run/dir FSM {IDLE, UP, DOWN}, counter, per-channel generate blocks.
// TESTING
//  - dir=down, one_shot=1, period=20, clk_src=0, tmr_en 0->1:
//    to_flag one pulse 21 ticks after load; tmr holds 0; no further flags.
//  - dir=up, periodic, period=10, clk_src=1:
//    to_flag every 22 clk; tmr sequence 0..10,0; tmr_en=0 freezes tmr.
//  - WIDTH=16, CH_NUM=2, dir=up, period=99:
//    - ch0 cmp=25: pwm high 25 ticks of 100, match_flag[0] each period.
//    - ch1 cmp=0: pwm stays low.
//  - dir=up-down, period=8, ch0 cmp=4: pwm centre-aligned, high 8 of 16 ticks; to_flag only at tmr==0.
//  - ch1 capture, cap_edge=11, toggle cap_in every 700 ns, clk_src=0:
//    cap_flag on each edge, cap_val equals tmr sampled 2 clk after edge.
//  - clk_src=9, ctr_in toggling, rst pulsed mid-count:
//    all outputs 0 asynchronously; after release, counting restarts only on new tmr_en rise.

Source files
------------

// File: rtl/ef_tcc_pkg.sv
// ef_tcc_pkg: shared encodings for the multi-channel timer/counter
package ef_tcc_pkg;
  localparam logic [3:0] CLK_SRC_EXT = 4'd9;
  localparam logic [1:0] DIR_UP      = 2'd0;
  localparam logic [1:0] DIR_DOWN    = 2'd1;
  localparam logic [1:0] DIR_UPDOWN  = 2'd2;
  localparam logic [1:0] CAP_RISE    = 2'b01;
  localparam logic [1:0] CAP_FALL    = 2'b10;
  localparam logic [1:0] CAP_BOTH    = 2'b11;
  localparam logic       CH_COMPARE  = 1'b0;
  localparam logic       CH_CAPTURE  = 1'b1;
  typedef enum logic [1:0] {ST_IDLE, ST_UP, ST_DOWN} st_t;
endpackage

// File: rtl/ef_tcc_sync_edge.sv
// ef_tcc_sync_edge: 2-FF synchroniser with a selectable rise/fall event pulse
module ef_tcc_sync_edge
  import ef_tcc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_d,
  input  logic [1:0] i_sel,
  output logic       o_evt
);
  logic [2:0] r_s;
  logic       w_rise;
  logic       w_fall;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_s <= '0;
    else r_s <= {r_s[1:0], i_d};
  assign w_rise = r_s[1] & ~r_s[2];
  assign w_fall = ~r_s[1] & r_s[2];
  assign o_evt = ((i_sel == CAP_RISE || i_sel == CAP_BOTH) && w_rise) ||
                 ((i_sel == CAP_FALL || i_sel == CAP_BOTH) && w_fall);
endmodule

// File: rtl/ef_tcc_nch.sv
// ef_tcc_nch: timer/counter with prescaler, up/down/up-down counting and
// CH_NUM compare (PWM) / input-capture channels
module ef_tcc_nch
  import ef_tcc_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CH_NUM = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    tmr_en,
  input  logic [3:0]              clk_src,
  input  logic                    ctr_in,
  input  logic [1:0]              dir,
  input  logic                    one_shot,
  input  logic [WIDTH-1:0]        period,
  input  logic [CH_NUM-1:0]       ch_mode,
  input  logic [CH_NUM*WIDTH-1:0] ch_cmp,
  input  logic [2*CH_NUM-1:0]     cap_edge,
  input  logic [CH_NUM-1:0]       cap_in,
  output logic [WIDTH-1:0]        tmr,
  output logic [CH_NUM*WIDTH-1:0] cap_val,
  output logic [CH_NUM-1:0]       pwm_out,
  output logic                    to_flag,
  output logic [CH_NUM-1:0]       match_flag,
  output logic [CH_NUM-1:0]       cap_flag
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  logic [7:0]       r_pre;
  logic [7:0]       w_mask;
  logic             r_en_d;
  logic             r_to;
  st_t              r_st;
  st_t              w_st;
  logic [WIDTH-1:0] r_tmr;
  logic [WIDTH-1:0] w_tmr;
  logic [1:0]       w_dir;
  logic             w_ext;
  logic             w_tick;
  logic             w_start;
  logic             w_to;
  logic             w_upd;
  logic             w_pset;
  ef_tcc_sync_edge u_ext (.clk, .rst, .i_d(ctr_in), .i_sel(CAP_RISE), .o_evt(w_ext));
  assign w_mask  = 8'((9'd1 << clk_src) - 9'd1);
  assign w_tick  = clk_src == CLK_SRC_EXT ? w_ext : clk_src < CLK_SRC_EXT && (r_pre & w_mask) == w_mask;
  assign w_dir   = dir == DIR_DOWN || dir == DIR_UPDOWN ? dir : DIR_UP;
  assign w_start = tmr_en && !r_en_d;
  // up-down keeps PWM state across the zero turnaround; other modes restart the cycle
  assign w_pset  = w_start || (w_to && !one_shot && w_dir != DIR_UPDOWN);
  always_comb begin
    w_st  = r_st;
    w_tmr = r_tmr;
    w_to  = 1'b0;
    w_upd = 1'b0;
    if (!tmr_en) w_st = ST_IDLE;
    else if (w_start) begin
      w_st  = w_dir == DIR_DOWN ? ST_DOWN : ST_UP;
      w_tmr = w_dir == DIR_DOWN ? period : '0;
    end else if (r_st != ST_IDLE && w_tick) begin
      w_upd = 1'b1;
      if (w_dir == DIR_UP) begin
        w_to  = r_tmr == period;
        w_tmr = w_to ? '0 : r_tmr + ONE;
        w_st  = ST_UP;
      end else if (w_dir == DIR_DOWN) begin
        w_to  = r_tmr == '0;
        w_tmr = w_to ? period : r_tmr - ONE;
        w_st  = ST_DOWN;
      end else if (period == '0) begin
        w_to  = 1'b1;
        w_tmr = '0;
        w_st  = ST_UP;
      end else if (r_st == ST_UP) begin
        w_st  = r_tmr == period ? ST_DOWN : ST_UP;
        w_tmr = r_tmr == period ? r_tmr - ONE : r_tmr + ONE;
      end else begin
        w_to  = r_tmr == '0;
        w_st  = w_to ? ST_UP : ST_DOWN;
        w_tmr = w_to ? r_tmr + ONE : r_tmr - ONE;
      end
      if (w_to && one_shot) begin
        w_st  = ST_IDLE;
        w_tmr = r_tmr;
      end
    end
  end
  // r_en_d resets high so a tmr_en held through reset needs a fresh rise
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_pre  <= '0;
      r_en_d <= 1'b1;
      r_st   <= ST_IDLE;
      r_tmr  <= '0;
      r_to   <= 1'b0;
    end else if (!en) begin
      r_pre  <= '0;
      r_en_d <= 1'b1;
      r_st   <= ST_IDLE;
      r_tmr  <= '0;
      r_to   <= 1'b0;
    end else begin
      r_pre  <= r_pre + 8'd1;
      r_en_d <= tmr_en;
      r_st   <= w_st;
      r_tmr  <= w_tmr;
      r_to   <= w_to;
    end
  assign tmr     = r_tmr;
  assign to_flag = r_to;
  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    logic [WIDTH-1:0] w_cmp;
    logic [WIDTH-1:0] r_cap;
    logic             w_cap;
    logic             w_cpt;
    logic             w_mt;
    logic             w_pwm;
    logic             r_pwm;
    logic             r_mf;
    logic             r_cf;
    assign w_cmp = ch_cmp[i*WIDTH +: WIDTH];
    assign w_cpt = ch_mode[i] == CH_CAPTURE;
    ef_tcc_sync_edge u_cap (.clk, .rst, .i_d(cap_in[i]), .i_sel(cap_edge[2*i +: 2]), .o_evt(w_cap));
    assign w_mt  = ch_mode[i] == CH_COMPARE && w_upd && w_tmr == w_cmp;
    assign w_pwm = w_cpt || w_cmp == '0 ? 1'b0 :
                   w_cmp > period || w_pset ? 1'b1 :
                   w_mt ? (w_dir == DIR_UPDOWN && w_st == ST_DOWN) : r_pwm;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        r_pwm <= 1'b0;
        r_mf  <= 1'b0;
        r_cf  <= 1'b0;
        r_cap <= '0;
      end else if (!en) begin
        r_pwm <= 1'b0;
        r_mf  <= 1'b0;
        r_cf  <= 1'b0;
        r_cap <= '0;
      end else begin
        r_pwm <= w_pwm;
        r_mf  <= w_mt;
        r_cf  <= w_cpt && w_cap;
        if (w_cpt && w_cap) r_cap <= r_tmr;
      end
    assign pwm_out[i]                = r_pwm;
    assign match_flag[i]             = r_mf;
    assign cap_flag[i]               = r_cf;
    assign cap_val[i*WIDTH +: WIDTH] = r_cap;
  end
endmodule

// File: tb/tb_ef_tcc_nch.sv
// tb_ef_tcc_nch: directed scoreboard bench for ef_tcc_nch (WIDTH=16, CH_NUM=2)
module tb_ef_tcc_nch;
  localparam int W = 16;
  localparam int N = 2;
  logic           clk = 1'b0, rst = 1'b1, en = 1'b1, tmr_en = 1'b0, one_shot = 1'b0, ctr_in = 1'b0;
  logic [3:0]     clk_src = '0;
  logic [1:0]     dir = '0;
  logic [W-1:0]   period = '0;
  logic [N-1:0]   ch_mode = '1, cap_in = '0;
  logic [N*W-1:0] ch_cmp = '0;
  logic [2*N-1:0] cap_edge = '0;
  logic [W-1:0]   tmr;
  logic [N*W-1:0] cap_val;
  logic [N-1:0]   pwm_out, match_flag, cap_flag;
  logic           to_flag;
  int n_chk = 0, n_err = 0, cyc = 0, last = 0;
  typedef struct {
    logic         to;
    logic [1:0]   mf;
    logic [1:0]   cf;
    logic [W-1:0] tmr;
    logic [W-1:0] cap;
    logic         pwm;
    int           gap;
  } ev_t;
  ev_t q[$];
  ev_t e;

  ef_tcc_nch #(.WIDTH(W), .CH_NUM(N)) dut (
    .clk(clk), .rst(rst), .en(en), .tmr_en(tmr_en), .clk_src(clk_src), .ctr_in(ctr_in),
    .dir(dir), .one_shot(one_shot), .period(period), .ch_mode(ch_mode), .ch_cmp(ch_cmp),
    .cap_edge(cap_edge), .cap_in(cap_in), .tmr(tmr), .cap_val(cap_val), .pwm_out(pwm_out),
    .to_flag(to_flag), .match_flag(match_flag), .cap_flag(cap_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (!rst && (to_flag || match_flag != 0 || cap_flag != 0)) begin
    n_chk++;
    if (q.size() == 0) begin
      n_err++;
      $display("FAIL event: unexpected to=%b mf=%b cf=%b tmr=%0d at cycle %0d, required no event",
               to_flag, match_flag, cap_flag, tmr, cyc);
    end else begin
      e = q.pop_front();
      if (to_flag !== e.to || match_flag !== e.mf || cap_flag !== e.cf || tmr !== e.tmr ||
          cap_val[2*W-1:W] !== e.cap || pwm_out[0] !== e.pwm || (e.gap != 0 && cyc - last != e.gap)) begin
        n_err++;
        $display("FAIL event: got to=%b mf=%b cf=%b tmr=%0d cap1=%0d pwm0=%b gap=%0d, expected to=%b mf=%b cf=%b tmr=%0d cap1=%0d pwm0=%b gap=%0d",
                 to_flag, match_flag, cap_flag, tmr, cap_val[2*W-1:W], pwm_out[0], cyc - last,
                 e.to, e.mf, e.cf, e.tmr, e.cap, e.pwm, e.gap);
      end
    end
    last = cyc;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input logic t, input logic [1:0] m, input logic [1:0] c,
                      input int tv, input int cv, input logic p, input int g);
    ev_t x;
    x.to = t; x.mf = m; x.cf = c; x.tmr = W'(tv); x.cap = W'(cv); x.pwm = p; x.gap = g;
    q.push_back(x);
  endtask

  task automatic wait_q(input int lim);
    int n = 0;
    while (q.size() != 0 && n < lim) begin
      @(negedge clk); #1;
      n++;
    end
    n_chk++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL wait_q: %0d events outstanding, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; tmr_en = 1'b0; ctr_in = 1'b0; cap_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic start();
    last = cyc + 1;
    tmr_en = 1'b1;
  endtask

  task automatic ext_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (4) @(negedge clk);
      ctr_in = 1'b1;
      repeat (4) @(negedge clk);
      ctr_in = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, c0, c, prev, mx, cnt0, cnt1;
    do_reset();
    chk("rst_tmr", 64'(tmr), 0);
    chk("rst_cap", 64'(cap_val), 0);
    chk("rst_pwm", 64'(pwm_out), 0);
    chk("rst_flags", 64'({to_flag, match_flag, cap_flag}), 0);
    // down one-shot
    dir = 2'd1; one_shot = 1'b1; period = 16'd20; clk_src = 4'd0;
    push(1, 2'b00, 2'b00, 0, 0, 0, 21);
    start();
    @(negedge clk);
    chk("down_load", 64'(tmr), 20);
    wait_q(40);
    repeat (30) @(negedge clk);
    chk("oneshot_hold", 64'(tmr), 0);
    // up periodic, clk/2
    do_reset();
    dir = 2'd0; one_shot = 1'b0; period = 16'd10; clk_src = 4'd1;
    push(1, 2'b00, 2'b00, 0, 0, 0, 0);
    push(1, 2'b00, 2'b00, 0, 0, 0, 22);
    push(1, 2'b00, 2'b00, 0, 0, 0, 22);
    start();
    mx = 0;
    for (int i = 0; i < 200 && q.size() != 0; i++) begin
      @(negedge clk); #1;
      if (int'(tmr) > mx) mx = int'(tmr);
    end
    chk("up_max", 64'(mx), 10);
    wait_q(1);
    tmr_en = 1'b0;
    repeat (20) @(negedge clk);
    chk("freeze", 64'(tmr), 0);
    // PWM compare, period 99
    do_reset();
    period = 16'd99; clk_src = 4'd0; ch_mode = 2'b00; ch_cmp = {16'd0, 16'd25};
    for (int k = 0; k < 2; k++) begin
      push(0, 2'b01, 2'b00, 25, 0, 0, 25);
      push(1, 2'b10, 2'b00, 0, 0, 1, 75);
    end
    start();
    cnt0 = 0; cnt1 = 0;
    repeat (100) begin
      @(negedge clk);
      cnt0 += int'(pwm_out[0]);
      cnt1 += int'(pwm_out[1]);
    end
    chk("pwm0_duty", 64'(cnt0), 25);
    chk("pwm1_low", 64'(cnt1), 0);
    wait_q(150);
    tmr_en = 1'b0;
    // up-down centre-aligned
    do_reset();
    dir = 2'd2; period = 16'd8; ch_mode = 2'b10; ch_cmp = {16'd0, 16'd4};
    push(0, 2'b01, 2'b00, 4, 0, 0, 4);
    push(0, 2'b01, 2'b00, 4, 0, 1, 8);
    push(1, 2'b00, 2'b00, 1, 0, 1, 5);
    push(0, 2'b01, 2'b00, 4, 0, 0, 3);
    push(0, 2'b01, 2'b00, 4, 0, 1, 8);
    push(1, 2'b00, 2'b00, 1, 0, 1, 5);
    start();
    cnt0 = 0;
    repeat (16) begin
      @(negedge clk);
      cnt0 += int'(pwm_out[0]);
    end
    chk("updown_duty", 64'(cnt0), 8);
    wait_q(40);
    tmr_en = 1'b0;
    // capture on both edges of cap_in[1]
    do_reset();
    dir = 2'd0; period = 16'd1000; ch_mode = 2'b11; cap_edge = 4'b1100; ch_cmp = '0;
    s = cyc;
    start();
    c0 = s + 1;
    prev = c0;
    for (int k = 0; k < 4; k++) begin
      repeat (70) @(negedge clk);
      c = cyc;
      push(0, 2'b00, 2'b10, c + 3 - c0, c + 2 - c0, 0, c + 3 - prev);
      prev = c + 3;
      cap_in[1] = ~cap_in[1];
    end
    wait_q(10);
    // external clock, async reset mid-count
    tmr_en = 1'b0;
    clk_src = 4'd9;
    @(negedge clk);
    start();
    ext_pulses(5);
    chk("ext_count", 64'(tmr), 5);
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst", 64'({tmr, cap_val, pwm_out, to_flag, match_flag, cap_flag}), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    ext_pulses(3);
    chk("no_restart", 64'(tmr), 0);
    tmr_en = 1'b0;
    @(negedge clk);
    tmr_en = 1'b1;
    ext_pulses(3);
    chk("restart", 64'(tmr), 3);
    en = 1'b0;
    repeat (2) @(negedge clk);
    chk("en_off", 64'(tmr), 0);
    en = 1'b1;
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
